// File: rtl/qam_pkg.sv
// Shared 64-QAM constants: per-axis Gray table and the level/threshold multipliers
// used by both the demapper and the mapper.
package qam_pkg;

  localparam int NUM_LEVELS = 8;
  localparam int NUM_THRESH = NUM_LEVELS - 1;

  // Gray code per level index 0..7, i.e. levels -7,-5,-3,-1,+1,+3,+5,+7
  localparam logic [23:0] GRAY_TABLE = {3'b100, 3'b101, 3'b111, 3'b110,
                                        3'b010, 3'b011, 3'b001, 3'b000};

  function automatic logic [2:0] gray_code(input logic [2:0] idx);
    return GRAY_TABLE[int'(idx)*3 +: 3];
  endfunction

  // Level multiplier k for a level index (amplitude = k*SCALE)
  function automatic int level_k(input logic [2:0] idx);
    return 2 * int'(idx) - 7;
  endfunction

  // Threshold multiplier for threshold j (0..6): -6,-4,-2,0,+2,+4,+6
  function automatic int thresh_k(input int j);
    return 2 * j - 6;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// Combinational hard slicer for one constellation axis: counts the thresholds the
// sample reaches (ties go up) and returns that level's Gray code.
module qam_slicer
  import qam_pkg::*;
#(
  parameter int W     = 16,
  parameter int SCALE = 2048
) (
  input  logic signed [W-1:0] axis,
  output logic        [2:0]   bits
);

  logic [2:0] idx;

  always_comb begin
    idx = '0;
    for (int j = 0; j < NUM_THRESH; j++) begin
      if (int'(axis) >= thresh_k(j) * SCALE) idx = idx + 3'd1;
    end
    bits = gray_code(idx);
  end

endmodule

// File: rtl/qam_demapper.sv
// 64-QAM demapper: slices I/Q, packs 6-bit symbols MSB-first into bytes with OFDM
// framing. Define QAM_DEMAP_DEBUG_EN to expose carry_over, co_count and sc_cnt.
module qam_demapper
  import qam_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 8,
  parameter int B     = 8,
  parameter int SCALE = 2048
) (
  input  logic           aclk,
  input  logic           reset,
  input  logic [2*W-1:0] s_data_in,
  input  logic           s_dvalid,
  output logic           s_dready,
  input  logic           s_dlast,
  output logic [B-1:0]   m_data_out,
  output logic           m_dvalid,
  input  logic           m_dready,
  output logic           m_dlast,
  output logic [9:0]     m_symbol_index,
  output logic           m_err
`ifdef QAM_DEMAP_DEBUG_EN
  ,
  output logic [15:0]    carry_over,
  output logic [5:0]     co_count,
  output logic [5:0]     sc_cnt
`endif
);

`ifdef QAM_DEMAP_DEBUG_EN
`else
  logic [15:0] carry_over;
  logic [5:0]  co_count;
  logic [5:0]  sc_cnt;
`endif

  localparam logic [5:0] B_W    = 6'(B);
  localparam logic [5:0] N_LAST = 6'(N - 1);

  logic [2:0]  i_bits, q_bits;
  logic [5:0]  sym;
  logic        in_fire, out_free, take, sc_is_last;
  logic [15:0] app_buf;
  logic [5:0]  app_cnt, app_mark;
  // Bit count up to and including the final bit of subcarrier N-1 (0 = none buffered)
  logic [5:0]  last_pos;

  qam_slicer #(.W(W), .SCALE(SCALE)) u_slice_i (
    .axis (s_data_in[2*W-1:W]),
    .bits (i_bits)
  );

  qam_slicer #(.W(W), .SCALE(SCALE)) u_slice_q (
    .axis (s_data_in[W-1:0]),
    .bits (q_bits)
  );

  assign sym        = {i_bits, q_bits};
  assign sc_is_last = (sc_cnt == N_LAST);
  assign s_dready   = (co_count <= 6'd10) && (co_count < B_W);
  assign in_fire    = s_dvalid && s_dready;
  assign out_free   = !m_dvalid || m_dready;

  // The incoming symbol is appended combinationally so a completed byte can be
  // handed to the output register on the same edge (one-cycle latency).
  always_comb begin
    app_buf  = carry_over;
    app_cnt  = co_count;
    app_mark = last_pos;
    if (in_fire) begin
      app_buf = carry_over | ({sym, 10'b0} >> co_count);
      app_cnt = co_count + 6'd6;
      if (sc_is_last) app_mark = app_cnt;
    end
    take = out_free && (app_cnt >= B_W);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      carry_over     <= '0;
      co_count       <= '0;
      sc_cnt         <= '0;
      last_pos       <= '0;
      m_data_out     <= '0;
      m_dvalid       <= 1'b0;
      m_dlast        <= 1'b0;
      m_err          <= 1'b0;
      m_symbol_index <= '0;
    end else begin
      if (in_fire) begin
        sc_cnt <= (s_dlast || sc_is_last) ? 6'd0 : sc_cnt + 6'd1;
        if (s_dlast != sc_is_last) m_err <= 1'b1;
      end

      if (m_dvalid && m_dready && m_dlast) m_symbol_index <= m_symbol_index + 10'd1;

      if (take) begin
        m_data_out <= app_buf[15 -: B];
        m_dvalid   <= 1'b1;
        m_dlast    <= (app_mark != 6'd0) && (app_mark <= B_W);
        carry_over <= app_buf << B;
        co_count   <= app_cnt - B_W;
        last_pos   <= (app_mark > B_W) ? app_mark - B_W : 6'd0;
      end else begin
        if (m_dready) begin
          m_dvalid <= 1'b0;
          m_dlast  <= 1'b0;
        end
        carry_over <= app_buf;
        co_count   <= app_cnt;
        last_pos   <= app_mark;
      end
    end
  end

endmodule

// File: tb/tb_qam_demapper.sv
// Randomized scoreboard bench for qam_demapper: a bit-level reference model queues
// expected bytes, and an independent monitor pops and compares on each output transfer.
module tb_qam_demapper;

  localparam int W = 16;
  localparam int N = 8;
  localparam int B = 8;
  localparam int SCALE = 2048;

  logic          aclk = 1'b0;
  logic          reset;
  logic [2*W-1:0] s_data_in;
  logic          s_dvalid;
  logic          s_dready;
  logic          s_dlast;
  logic [B-1:0]  m_data_out;
  logic          m_dvalid;
  logic          m_dready;
  logic          m_dlast;
  logic [9:0]    m_symbol_index;
  logic          m_err;

  always #5 aclk = ~aclk;

  qam_demapper #(.W(W), .N(N), .B(B), .SCALE(SCALE)) dut (
    .aclk           (aclk),
    .reset          (reset),
    .s_data_in      (s_data_in),
    .s_dvalid       (s_dvalid),
    .s_dready       (s_dready),
    .s_dlast        (s_dlast),
    .m_data_out     (m_data_out),
    .m_dvalid       (m_dvalid),
    .m_dready       (m_dready),
    .m_dlast        (m_dlast),
    .m_symbol_index (m_symbol_index),
    .m_err          (m_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [9:0] idx;
  } exp_t;

  exp_t exp_q[$];
  bit   bit_q[$];
  bit   tag_q[$];
  int   m_sc;
  bit   m_err_exp;
  int   m_sym;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int   stalls;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Level index is the floor of x/(2*SCALE), offset and clamped to 0..7
  function automatic logic [2:0] model_slice(input logic [15:0] v);
    int  gray[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    real f;
    int  k;
    f = $floor(real'($signed(v)) / (2.0 * SCALE));
    k = int'(f) + 4;
    if (k < 0) k = 0;
    if (k > 7) k = 7;
    return 3'(gray[k]);
  endfunction

  task automatic modelPush(input logic [15:0] iv, input logic [15:0] qv, input bit last);
    logic [5:0] sym;
    bit end_sc;
    exp_t e;
    sym = {model_slice(iv), model_slice(qv)};
    end_sc = (m_sc == N - 1);
    if (last != end_sc) m_err_exp = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      bit_q.push_back(sym[i]);
      tag_q.push_back(end_sc && (i == 0));
    end
    m_sc = (last || end_sc) ? 0 : m_sc + 1;
    while (bit_q.size() >= B) begin
      e = '0;
      for (int b = 0; b < B; b++) begin
        e.data = {e.data[6:0], bit_q.pop_front()};
        if (tag_q.pop_front()) e.last = 1'b1;
      end
      e.idx = 10'(m_sym);
      exp_q.push_back(e);
      if (e.last) m_sym = (m_sym + 1) % 1024;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    exp_q.delete();
    bit_q.delete();
    tag_q.delete();
    m_sc = 0;
    m_err_exp = 1'b0;
    m_sym = 0;
    #1 reset = 1'b0;
  endtask

  // Holds one sample until accepted; counts cycles where the block was not ready
  task automatic applyStimulus(input logic [15:0] iv, input logic [15:0] qv, input bit last);
    bit done = 0;
    s_data_in = {iv, qv};
    s_dlast   = last;
    s_dvalid  = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      if (s_dready) begin
        modelPush(iv, qv, last);
        @(posedge aclk);
        #1;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) checkOutput("input_accept_timeout", 0, 1);
  endtask

  task automatic idleInput();
    s_dvalid = 1'b0;
    s_dlast  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge aclk);
    if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
    repeat (5) @(posedge aclk);
    #1;
  endtask

  initial begin
    m_dready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_dready = 1'b1;
        1: m_dready = 1'b0;
        default: m_dready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on each output transfer and checks outputs hold while stalled
  initial begin
    bit   held = 0;
    exp_t h;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (reset) begin
        held = 0;
      end else if (m_dvalid) begin
        if (held) begin
          checkOutput("stall_data_stable", m_data_out, h.data);
          checkOutput("stall_last_stable", m_dlast, h.last);
        end
        if (m_dready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", m_data_out);
          end else begin
            e = exp_q.pop_front();
            checkOutput("byte_data", m_data_out, e.data);
            checkOutput("byte_last", m_dlast, e.last);
            checkOutput("symbol_index", m_symbol_index, e.idx);
          end
          held = 0;
        end else begin
          held = 1;
          h.data = m_data_out;
          h.last = m_dlast;
        end
      end else if (held) begin
        checkOutput("valid_dropped_while_stalled", 0, 1);
        held = 0;
      end
    end
  end

  initial begin
    logic [15:0] thr[8] = '{16'h1000, 16'h0FFF, 16'h0000, 16'h8000,
                            16'h7FFF, 16'hF000, 16'hEFFF, 16'h3000};
    reset = 1'b1;
    idleInput();
    s_data_in = '0;
    m_sc = 0;
    m_err_exp = 1'b0;
    m_sym = 0;

    // Reset state
    doReset();
    checkOutput("reset_m_dvalid", m_dvalid, 0);
    checkOutput("reset_m_err", m_err, 0);
    checkOutput("reset_m_dlast", m_dlast, 0);
    checkOutput("reset_symbol_index", m_symbol_index, 0);
    checkOutput("reset_s_dready", s_dready, 1);

    // +7/-7 burst with s_dlast held high: bytes 82 08 20, no bubbles, framing error
    rdy_mode = 0;
    stalls = 0;
    applyStimulus(16'h3800, 16'hC800, 1'b1);
    checkOutput("no_byte_after_one_symbol", m_dvalid, 0);
    applyStimulus(16'h3800, 16'hC800, 1'b1);
    checkOutput("latency_first_byte", m_dvalid, 1);
    applyStimulus(16'h3800, 16'hC800, 1'b1);
    applyStimulus(16'h3800, 16'hC800, 1'b1);
    idleInput();
    checkOutput("burst_no_bubbles", stalls, 0);
    waitDrain();
    checkOutput("dlast_everywhere_err", m_err, m_err_exp);
    doReset();

    // Threshold values on I, mirrored on Q, as one well-framed OFDM symbol
    rdy_mode = 2;
    for (int i = 0; i < N; i++) applyStimulus(thr[i], ~thr[i], i == N - 1);
    idleInput();
    waitDrain();

    // Random well-framed symbols with random backpressure
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++)
        applyStimulus(16'($urandom), 16'($urandom), i == N - 1);
      if (s == 2) idleInput();
    end
    idleInput();
    waitDrain();
    checkOutput("clean_frames_no_err", m_err, 0);
    checkOutput("symbol_index_after_frames", m_symbol_index, m_sym);

    // Early s_dlast on sample 5, then a normal 8-sample symbol
    for (int i = 0; i < 5; i++) applyStimulus(16'($urandom), 16'($urandom), i == 4);
    for (int i = 0; i < N; i++) applyStimulus(16'($urandom), 16'($urandom), i == N - 1);
    idleInput();
    waitDrain();
    checkOutput("framing_err_sticky", m_err, 1);
    checkOutput("framing_err_model", m_err, m_err_exp);

    // Reset mid-symbol with output stalled, then a fresh 4-sample burst
    rdy_mode = 1;
    repeat (2) @(posedge aclk);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b0);
    idleInput();
    repeat (3) @(posedge aclk);
    doReset();
    checkOutput("midreset_m_dvalid", m_dvalid, 0);
    checkOutput("midreset_s_dready", s_dready, 1);
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b0);
    idleInput();
    waitDrain();
    checkOutput("post_reset_no_err", m_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
